// File: rtl/cape_gpio_apb.sv
// APB GPIO bank for the cape pads: OUT/OE registers, synchronised inputs, edge/level IRQs.
// Optional input debounce is built when CAPE_GPIO_DEBOUNCE_EN is defined.
module cape_gpio_apb #(
    parameter int NUM_GPIO    = 28,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [7:0]          PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    input  logic [NUM_GPIO-1:0] GPIO_IN,
    output logic [NUM_GPIO-1:0] GPIO_OUT,
    output logic [NUM_GPIO-1:0] GPIO_OE,
    output logic [NUM_GPIO-1:0] INT,
    output logic                IRQ
);

    typedef enum logic [5:0] {
        A_OUT    = 6'h00,
        A_OE     = 6'h01,
        A_IN     = 6'h02,
        A_EN     = 6'h03,
        A_TYPE   = 6'h04,
        A_POL    = 6'h05,
        A_STATUS = 6'h06,
        A_SET    = 6'h07,
        A_CLR    = 6'h08,
        A_DEB    = 6'h09
    } reg_addr_e;

    logic [5:0]          word;
    logic                wr;
    logic                rd;
    logic [NUM_GPIO-1:0] wdata;
    logic                unused_bits;

    logic [NUM_GPIO-1:0] out_q, oe_q, en_q, type_q, pol_q, status_q, prev_q;
    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] warm_q;
    logic [NUM_GPIO-1:0] in_val;
    logic [NUM_GPIO-1:0] evt;
    logic [31:0]         rdata;

    assign word        = PADDR[7:2];
    assign wr          = PSEL & PENABLE & PWRITE;
    assign rd          = PSEL & ~PENABLE & ~PWRITE;
    assign wdata       = PWDATA[NUM_GPIO-1:0];
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= GPIO_IN;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

`ifdef CAPE_GPIO_DEBOUNCE_EN
    logic [15:0]         deb_q, presc_q;
    logic [NUM_GPIO-1:0] samp_q, in_q, agree;
    logic                tick;

    assign tick  = (presc_q == deb_q);
    assign agree = ~(sync_q[SYNC_STAGES-1] ^ samp_q);

    // IN follows the synchronised value only once two consecutive ticks agree
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            deb_q   <= '0;
            presc_q <= '0;
            samp_q  <= '0;
            in_q    <= '0;
        end else begin
            if (wr && word == A_DEB) deb_q <= PWDATA[15:0];
            presc_q <= tick ? '0 : presc_q + 16'd1;
            if (tick) begin
                samp_q <= sync_q[SYNC_STAGES-1];
                in_q   <= (in_q & ~agree) | (sync_q[SYNC_STAGES-1] & agree);
            end
        end
    end
    assign in_val = in_q;
`else
    assign in_val = sync_q[SYNC_STAGES-1];
`endif

    // Events are held off until the synchroniser has filled after reset
    assign evt = warm_q[SYNC_STAGES-1]
               ? (((type_q & (in_val ^ prev_q)) | ~type_q) & ~(in_val ^ pol_q))
               : '0;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            out_q    <= '0;
            oe_q     <= '0;
            en_q     <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            status_q <= '0;
            prev_q   <= '0;
            PRDATA   <= '0;
        end else begin
            prev_q <= in_val;
            if (wr) begin
                case (word)
                    A_OUT:  out_q  <= wdata;
                    A_OE:   oe_q   <= wdata;
                    A_EN:   en_q   <= wdata;
                    A_TYPE: type_q <= wdata;
                    A_POL:  pol_q  <= wdata;
                    A_SET:  out_q  <= out_q | wdata;
                    A_CLR:  out_q  <= out_q & ~wdata;
                    default: ;
                endcase
            end
            status_q <= (status_q & ~((wr && word == A_STATUS) ? wdata : '0)) | evt;
            if (rd) PRDATA <= rdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (word)
            A_OUT:    rdata[NUM_GPIO-1:0] = out_q;
            A_OE:     rdata[NUM_GPIO-1:0] = oe_q;
            A_IN:     rdata[NUM_GPIO-1:0] = in_val;
            A_EN:     rdata[NUM_GPIO-1:0] = en_q;
            A_TYPE:   rdata[NUM_GPIO-1:0] = type_q;
            A_POL:    rdata[NUM_GPIO-1:0] = pol_q;
            A_STATUS: rdata[NUM_GPIO-1:0] = status_q;
`ifdef CAPE_GPIO_DEBOUNCE_EN
            A_DEB:    rdata[15:0]         = deb_q;
`endif
            default:  rdata = '0;
        endcase
    end

    assign GPIO_OUT = out_q;
    assign GPIO_OE  = oe_q;
    assign INT      = status_q & en_q;
    assign IRQ      = |INT;

endmodule

// File: tb/tb_cape_gpio_apb.sv
// Scoreboard bench for cape_gpio_apb: 28-pin instance plus an 8-pin instance on the same APB bus.
module tb_cape_gpio_apb;

    localparam int K_PRDATA = 0, K_OUT = 1, K_OE = 2, K_IRQ = 3, K_INT = 4, K_PRDATA8 = 5;
`ifdef CAPE_GPIO_DEBOUNCE_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic        clk = 0;
    logic        rst_n = 0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata, prdata8;
    logic [27:0] gpio_in = 28'hFFFFFF7;
    logic [27:0] gpio_out, gpio_oe, gpio_int;
    logic [7:0]  out8, oe8, int8;
    logic        irq, irq8;

    int n_checks = 0;
    int n_fail   = 0;

    int          q_kind [$];
    logic [31:0] q_val  [$];
    string       q_name [$];

    always #5 clk = ~clk;

    cape_gpio_apb #(.NUM_GPIO(28), .SYNC_STAGES(2)) dut (
        .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .GPIO_IN(gpio_in),
        .GPIO_OUT(gpio_out), .GPIO_OE(gpio_oe), .INT(gpio_int), .IRQ(irq)
    );

    cape_gpio_apb #(.NUM_GPIO(8), .SYNC_STAGES(2)) dut8 (
        .PCLK(clk), .PRESETN(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata8), .GPIO_IN(gpio_in[7:0]),
        .GPIO_OUT(out8), .GPIO_OE(oe8), .INT(int8), .IRQ(irq8)
    );

    task automatic chk(input int kind, input logic [31:0] val, input string name);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [7:0] a);
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        psel = 0; penable = 0;
    endtask

    // Monitor: drains every pending expectation against the DUT outputs at the falling edge
    logic [31:0] act, expv;
    int          kind;
    string       nm;
    always @(negedge clk) begin
        while (q_val.size() > 0) begin
            kind = q_kind.pop_front();
            expv = q_val.pop_front();
            nm   = q_name.pop_front();
            case (kind)
                K_PRDATA:  act = prdata;
                K_OUT:     act = {4'h0, gpio_out};
                K_OE:      act = {4'h0, gpio_oe};
                K_IRQ:     act = {31'h0, irq};
                K_INT:     act = {4'h0, gpio_int};
                default:   act = prdata8;
            endcase
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk(K_PRDATA, 32'h0, "reset_prdata");
        chk(K_OUT,    32'h0, "reset_out");
        chk(K_OE,     32'h0, "reset_oe");
        chk(K_IRQ,    32'h0, "reset_irq");
        chk(K_INT,    32'h0, "reset_int");
        rst_n = 1;

        apb_write(8'h04, 32'h0000_00FF); chk(K_OE,  32'hFF, "oe_write");
        apb_write(8'h1C, 32'h0000_000F); chk(K_OUT, 32'h0F, "out_set");
        apb_write(8'h20, 32'h0000_0005); chk(K_OUT, 32'h0A, "out_clr");
        apb_read(8'h00); chk(K_PRDATA, 32'h0A, "rd_out"); chk(K_PRDATA8, 32'h0A, "rd_out8");
        apb_read(8'h04); chk(K_PRDATA, 32'hFF, "rd_oe");

        apb_write(8'h00, 32'hFFFF_FFFF);
        apb_read(8'h00); chk(K_PRDATA, 32'h0FFF_FFFF, "rd_out_mask28"); chk(K_PRDATA8, 32'hFF, "rd_out_mask8");
        apb_write(8'h40, 32'h1234_5678);
        apb_read(8'h40); chk(K_PRDATA, 32'h0, "rd_unmapped"); chk(K_PRDATA8, 32'h0, "rd_unmapped8");
        apb_read(8'h1C); chk(K_PRDATA, 32'h0, "rd_wo_set");
        apb_read(8'h00); chk(K_PRDATA, 32'h0FFF_FFFF, "rd_out_after_unmapped");
        apb_write(8'h00, 32'h0000_000A); chk(K_OUT, 32'h0A, "out_restore");

        apb_write(8'h10, 32'hFFFF_FFDF);
        apb_write(8'h14, 32'h0000_000C);
        apb_write(8'h18, 32'hFFFF_FFFF);
        apb_read(8'h18); chk(K_PRDATA, 32'h0, "status_cleared");
        apb_read(8'h08); chk(K_PRDATA, 32'h0FFF_FFF7, "rd_in");
        apb_write(8'h0C, 32'h0000_002C);
        apb_read(8'h0C); chk(K_PRDATA, 32'h2C, "rd_irq_en");
        chk(K_IRQ, 32'h0, "irq_idle");

        // rising edge on pin 3: STATUS/IRQ exactly SYNC_STAGES+1 edges after the pad change
        gpio_in[3] = 1'b1;
        repeat (2 + EXTRA) @(posedge clk);
        #1; chk(K_IRQ, 32'h0, "pin3_irq_early");
        @(posedge clk);
        #1; chk(K_IRQ, 32'h1, "pin3_irq"); chk(K_INT, 32'h8, "pin3_int");
        apb_read(8'h18); chk(K_PRDATA, 32'h8, "pin3_status");
        apb_write(8'h18, 32'h8); chk(K_IRQ, 32'h0, "pin3_w1c_irq");

        // level-low pin 5: clear ineffective while held low
        gpio_in[5] = 1'b0;
        repeat (8) @(posedge clk);
        #1; chk(K_INT, 32'h20, "pin5_int");
        apb_write(8'h18, 32'h20);
        apb_read(8'h18); chk(K_PRDATA, 32'h20, "pin5_sticky");
        gpio_in[5] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        apb_write(8'h18, 32'h20);
        apb_read(8'h18); chk(K_PRDATA, 32'h0, "pin5_cleared");
        chk(K_IRQ, 32'h0, "pin5_irq_off");

        // pin 2: falling edge ignored, then rising event lands on the W1C commit edge
        gpio_in[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        apb_read(8'h18); chk(K_PRDATA, 32'h0, "pin2_fall_ignored");
        gpio_in[2] = 1'b1;
        repeat (EXTRA) @(posedge clk);
        apb_write(8'h18, 32'h4);
        apb_read(8'h18); chk(K_PRDATA, 32'h4, "pin2_event_wins");
        chk(K_INT, 32'h4, "pin2_int");
        apb_write(8'h18, 32'h4);
        apb_read(8'h18); chk(K_PRDATA, 32'h0, "pin2_cleared");

`ifdef CAPE_GPIO_DEBOUNCE_EN
        apb_write(8'h24, 32'h3);
        apb_read(8'h24); chk(K_PRDATA, 32'h3, "rd_debounce");
        gpio_in[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1; gpio_in[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        apb_read(8'h08); chk(K_PRDATA, 32'h0FFF_FFFF, "glitch_in");
        apb_read(8'h18); chk(K_PRDATA, 32'h0, "glitch_status");
        gpio_in[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        apb_read(8'h08); chk(K_PRDATA, 32'h0FFF_FFFE, "pulse_in");
        apb_read(8'h18); chk(K_PRDATA, 32'h1, "pulse_status");
`else
        apb_write(8'h24, 32'h3);
        apb_read(8'h24); chk(K_PRDATA, 32'h0, "rd_debounce_absent");
`endif

        repeat (3) @(negedge clk);
        #1;
        if (q_val.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_val.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
